// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel strobe, h/v scan counters, and a
// pixel-tick delay line that re-aligns renderer colour with hs/vs.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int COLOR_W   = 4,
   parameter int PIX_DIV   = 4,
   parameter int FETCH_LAT = 1,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [3*COLOR_W-1:0]   d_in,
   output logic [11:0]            x,
   output logic [11:0]            y,
   output logic                   pix_ce,
   output logic                   frame_start,
   output logic [COLOR_W-1:0]     r,
   output logic [COLOR_W-1:0]     g,
   output logic [COLOR_W-1:0]     b,
   output logic                   hs,
   output logic                   vs
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int PW      = FETCH_LAT + 1;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
   localparam logic [11:0]      H_LAST  = 12'(H_TOTAL - 1);
   localparam logic [11:0]      V_LAST  = 12'(V_TOTAL - 1);

   // 13-bit bounds so a sync edge landing exactly on 4096 still compares correctly
   localparam logic [12:0] H_ACT13  = 13'(H_ACTIVE);
   localparam logic [12:0] H_SON13  = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] H_SOFF13 = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] V_ACT13  = 13'(V_ACTIVE);
   localparam logic [12:0] V_SON13  = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] V_SOFF13 = 13'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0]   div_cnt;
   logic               run;
   logic [11:0]        h_cnt;
   logic [11:0]        v_cnt;
   logic               act_raw;
   logic               hs_raw;
   logic               vs_raw;
   logic [PW-1:0]      act_sr;
   logic [PW-1:0]      hs_sr;
   logic [PW-1:0]      vs_sr;
   logic [3*COLOR_W-1:0] rgb_q;

   // run holds the divider for one clk after reset so the first strobe lands PIX_DIV clks out
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run     <= 1'b0;
         div_cnt <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            if (div_cnt == DIV_MAX) div_cnt <= '0;
            else                    div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   assign pix_ce = run && (div_cnt == DIV_MAX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (pix_ce) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               if (v_cnt == V_LAST) begin
                  v_cnt       <= '0;
                  frame_start <= 1'b1;
               end else begin
                  v_cnt <= v_cnt + 12'd1;
               end
            end else begin
               h_cnt <= h_cnt + 12'd1;
            end
         end
      end
   end

   assign x = h_cnt;
   assign y = v_cnt;

   assign act_raw = ({1'b0, h_cnt} < H_ACT13) && ({1'b0, v_cnt} < V_ACT13);
   assign hs_raw  = ({1'b0, h_cnt} >= H_SON13) && ({1'b0, h_cnt} < H_SOFF13);
   assign vs_raw  = ({1'b0, v_cnt} >= V_SON13) && ({1'b0, v_cnt} < V_SOFF13);

   // colour is captured on the strobe that ends tick k+FETCH_LAT, the same
   // strobe that shifts the flags of tick k into the last delay stage
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         act_sr <= '0;
         hs_sr  <= '0;
         vs_sr  <= '0;
         rgb_q  <= '0;
      end else if (pix_ce) begin
         act_sr <= (act_sr << 1) | PW'(act_raw);
         hs_sr  <= (hs_sr << 1)  | PW'(hs_raw);
         vs_sr  <= (vs_sr << 1)  | PW'(vs_raw);
         rgb_q  <= d_in;
      end
   end

   assign r  = act_sr[FETCH_LAT] ? rgb_q[3*COLOR_W-1 -: COLOR_W] : '0;
   assign g  = act_sr[FETCH_LAT] ? rgb_q[2*COLOR_W-1 -: COLOR_W] : '0;
   assign b  = act_sr[FETCH_LAT] ? rgb_q[COLOR_W-1:0]            : '0;
   assign hs = hs_sr[FETCH_LAT] ^ ~SYNC_POL;
   assign vs = vs_sr[FETCH_LAT] ^ ~SYNC_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four small-config instances (fetch latency 1/0/3,
// and a PIX_DIV=1 active-high-sync variant) checked every clk against tick arithmetic.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   bit   mon_en = 1'b0;
   int   k;
   int   n_a, n_d;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   logic [11:0] x_a, y_a, x_b, y_b, x_c, y_c, x_d, y_d;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c, r_d, g_d, b_d;
   logic        pce_a, pce_b, pce_c, pce_d, fs_a, fs_b, fs_c, fs_d;
   logic        hs_a, vs_a, hs_b, vs_b, hs_c, vs_c, hs_d, vs_d;
   logic [11:0] d_a, d_b, d_c, d_d;
   logic [11:0] ren_a, ren_d, ren_c0, ren_c1, ren_c2;

   // renderer models: return {x,y,A} FETCH_LAT pixel ticks after the coordinate
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ren_a <= '0; ren_d <= '0; ren_c0 <= '0; ren_c1 <= '0; ren_c2 <= '0;
      end else begin
         if (pce_a) ren_a <= {x_a[3:0], y_a[3:0], 4'hA};
         if (pce_d) ren_d <= {x_d[3:0], y_d[3:0], 4'hA};
         if (pce_c) begin
            ren_c0 <= {x_c[3:0], y_c[3:0], 4'hA};
            ren_c1 <= ren_c0;
            ren_c2 <= ren_c1;
         end
      end
   end
   assign d_a = ren_a;
   assign d_b = {x_b[3:0], y_b[3:0], 4'hA};
   assign d_c = ren_c2;
   assign d_d = ren_d;

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .COLOR_W(4), .PIX_DIV(2), .FETCH_LAT(1), .SYNC_POL(1'b0)) dut_a (
      .clk(clk), .rstn(rstn), .d_in(d_a), .x(x_a), .y(y_a), .pix_ce(pce_a),
      .frame_start(fs_a), .r(r_a), .g(g_a), .b(b_a), .hs(hs_a), .vs(vs_a));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .COLOR_W(4), .PIX_DIV(2), .FETCH_LAT(0), .SYNC_POL(1'b0)) dut_b (
      .clk(clk), .rstn(rstn), .d_in(d_b), .x(x_b), .y(y_b), .pix_ce(pce_b),
      .frame_start(fs_b), .r(r_b), .g(g_b), .b(b_b), .hs(hs_b), .vs(vs_b));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .COLOR_W(4), .PIX_DIV(2), .FETCH_LAT(3), .SYNC_POL(1'b0)) dut_c (
      .clk(clk), .rstn(rstn), .d_in(d_c), .x(x_c), .y(y_c), .pix_ce(pce_c),
      .frame_start(fs_c), .r(r_c), .g(g_c), .b(b_c), .hs(hs_c), .vs(vs_c));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .COLOR_W(4), .PIX_DIV(1), .FETCH_LAT(1), .SYNC_POL(1'b1)) dut_d (
      .clk(clk), .rstn(rstn), .d_in(d_d), .x(x_d), .y(y_d), .pix_ce(pce_d),
      .frame_start(fs_d), .r(r_d), .g(g_d), .b(b_d), .hs(hs_d), .vs(vs_d));

   always @(posedge clk or negedge rstn) begin
      if (!rstn) k <= 0;
      else       k <= k + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s k=%0d got=%0d want=%0d", tag, k, obs, exp);
      end
   endtask

   // n = pixel tick index since reset release; outputs show the coordinate of tick n-lat-1
   task automatic check_dut(input string nm, input int n, input int lat, input bit pol,
                            input int xo, input int yo, input int ro, input int go,
                            input int bo, input int hso, input int vso);
      int m, h, v;
      bit act, hr, vr;
      chk({nm, ".x"}, xo, n % 16);
      chk({nm, ".y"}, yo, (n / 16) % 8);
      m = n - lat - 1;
      act = 1'b0; hr = 1'b0; vr = 1'b0; h = 0; v = 0;
      if (m >= 0) begin
         h   = m % 16;
         v   = (m / 16) % 8;
         act = (h < 8) && (v < 4);
         hr  = (h >= 10) && (h <= 12);
         vr  = (v == 5) || (v == 6);
      end
      chk({nm, ".r"}, ro, act ? h : 0);
      chk({nm, ".g"}, go, act ? v : 0);
      chk({nm, ".b"}, bo, act ? 10 : 0);
      chk({nm, ".hs"}, hso, pol ? int'(hr) : int'(!hr));
      chk({nm, ".vs"}, vso, pol ? int'(vr) : int'(!vr));
   endtask

   task automatic chk_rst(input string nm, input bit pol, input int xo, input int yo,
                          input int ro, input int go, input int bo, input int hso,
                          input int vso, input int pce, input int fs);
      chk({nm, ".rst_x"}, xo, 0);
      chk({nm, ".rst_y"}, yo, 0);
      chk({nm, ".rst_rgb"}, ro + go + bo, 0);
      chk({nm, ".rst_hs"}, hso, pol ? 0 : 1);
      chk({nm, ".rst_vs"}, vso, pol ? 0 : 1);
      chk({nm, ".rst_pix_ce"}, pce, 0);
      chk({nm, ".rst_frame_start"}, fs, 0);
   endtask

   always @(negedge clk) begin
      if (mon_en && rstn) begin
         n_a = (k >= 3) ? (k - 1) / 2 : 0;
         n_d = (k >= 2) ? k - 1 : 0;
         chk("a.pix_ce", pce_a, int'(k >= 2 && k % 2 == 0));
         chk("a.frame_start", fs_a, int'(k % 2 == 1 && n_a > 0 && n_a % 128 == 0));
         chk("c.pix_ce", pce_c, int'(k >= 2 && k % 2 == 0));
         chk("d.pix_ce", pce_d, int'(k >= 1));
         chk("d.frame_start", fs_d, int'(n_d > 0 && n_d % 128 == 0));
         check_dut("a", n_a, 1, 1'b0, x_a, y_a, r_a, g_a, b_a, hs_a, vs_a);
         check_dut("b", n_a, 0, 1'b0, x_b, y_b, r_b, g_b, b_b, hs_b, vs_b);
         check_dut("c", n_a, 3, 1'b0, x_c, y_c, r_c, g_c, b_c, hs_c, vs_c);
         check_dut("d", n_d, 1, 1'b1, x_d, y_d, r_d, g_d, b_d, hs_d, vs_d);
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk_rst("a", 1'b0, x_a, y_a, r_a, g_a, b_a, hs_a, vs_a, pce_a, fs_a);
      chk_rst("d", 1'b1, x_d, y_d, r_d, g_d, b_d, hs_d, vs_d, pce_d, fs_d);
      @(negedge clk);
      #2;
      rstn   = 1'b1;
      mon_en = 1'b1;
      // dut_a reaches x=5,y=2 (tick 37) at the 75th clk; its visible pixel is then (3,2)
      repeat (75) @(negedge clk);
      chk("a.mid_r_before_rst", r_a, 3);
      #1;
      rstn = 1'b0;
      #1;
      chk_rst("a", 1'b0, x_a, y_a, r_a, g_a, b_a, hs_a, vs_a, pce_a, fs_a);
      chk_rst("c", 1'b0, x_c, y_c, r_c, g_c, b_c, hs_c, vs_c, pce_c, fs_c);
      chk_rst("d", 1'b1, x_d, y_d, r_d, g_d, b_d, hs_d, vs_d, pce_d, fs_d);
      repeat (3) @(negedge clk);
      #2;
      rstn = 1'b1;
      repeat (600) @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
